// File: rtl/cpu_mem_pkg.sv
// Shared SCPU memory-side definitions: fetch FSM states and instruction word defaults.
package cpu_mem_pkg;

  localparam int INST_WORD_W = 32;
  localparam logic [INST_WORD_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sp_ram_rbw.sv
// Single-port-read / single-port-write RAM with a registered read port.
// A read and a write to the same word in one cycle return the old contents.
module sp_ram_rbw #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read and write in one process give read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_wait.sv
// Instruction memory with a req/ready fetch handshake, programmable wait states,
// a program-load write port and fault reporting for misaligned or out-of-range PCs.
module inst_mem_wait
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = INST_WORD_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              req,
  output logic [DATA_W-1:0] inst_out,
  output logic              ready,
  output logic              fault,
  output logic              busy,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  fetch_state_e state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bad_q, bad_d;
  logic             fault_q, fault_d;
  logic             nop_sel_q, nop_sel_d;

  logic [IDX_W-1:0]  pc_idx;
  logic              pc_misaligned;
  logic              pc_oor;
  logic              pc_bad;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign pc_idx        = pc_in[2 +: IDX_W];
  assign pc_misaligned = |pc_in[1:0];

  // Any set bit above the word index means the PC points past the array.
  if (ADDR_W > IDX_W + 2) begin : g_range
    assign pc_oor = |pc_in[ADDR_W-1:IDX_W+2];
  end else begin : g_no_range
    assign pc_oor = 1'b0;
  end

  assign pc_bad = pc_misaligned | pc_oor;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    bad_d      = bad_q;
    fault_d    = fault_q;
    nop_sel_d  = nop_sel_q;
    ram_re     = 1'b0;
    ram_raddr  = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (req) begin
          idx_d = pc_idx;
          bad_d = pc_bad;
          if (WAIT_CYCLES > 0) begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_INIT;
          end else begin
            // Zero wait states: read straight from pc_in, latched copy isn't valid yet.
            state_d   = DONE;
            ram_re    = 1'b1;
            ram_raddr = pc_idx;
            fault_d   = pc_bad;
            nop_sel_d = pc_bad;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d   = DONE;
          ram_re    = 1'b1;
          fault_d   = bad_q;
          nop_sel_d = bad_q;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      bad_q      <= 1'b0;
      fault_q    <= 1'b0;
      nop_sel_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      bad_q      <= bad_d;
      fault_q    <= fault_d;
      nop_sel_q  <= nop_sel_d;
    end
  end

  sp_ram_rbw #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re & ~reset),
    .raddr (ram_raddr),
    .rdata (ram_rdata),
    .we    (prog_we & ~reset),
    .waddr (prog_addr),
    .wdata (prog_data)
  );

  // The RAM read register holds between fetches, so it doubles as the inst_out register.
  assign inst_out = nop_sel_q ? NOP_INST : ram_rdata;
  assign ready    = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign fault    = fault_q;

endmodule

// File: tb/tb_inst_mem_wait.sv
// Bench for inst_mem_wait: three instances (0, 3 and 5 wait states) share one stimulus
// stream, each checked every cycle against a transaction-level model, plus literal checks.
module tb_inst_mem_wait;

   localparam int NDUT = 3;
   localparam int WAITS [NDUT] = '{0, 3, 5};
   localparam int W0 = 0;
   localparam int W3 = 1;
   localparam int W5 = 2;

   logic        clock;
   logic        reset;
   logic [31:0] pcIn;
   logic        req;
   logic        progWe;
   logic [7:0]  progAddr;
   logic [31:0] progData;

   logic [31:0] instV  [NDUT];
   logic        readyV [NDUT];
   logic        faultV [NDUT];
   logic        busyV  [NDUT];

   int checks = 0;
   int errors = 0;

   // One DUT per wait-state setting, all driven by the same inputs
   for (genvar g = 0; g < NDUT; g++) begin : gDut
      inst_mem_wait #(
         .WAIT_CYCLES (WAITS[g])
      ) dut (
         .clk       (clock),
         .reset     (reset),
         .pc_in     (pcIn),
         .req       (req),
         .inst_out  (instV[g]),
         .ready     (readyV[g]),
         .fault     (faultV[g]),
         .busy      (busyV[g]),
         .prog_we   (progWe),
         .prog_addr (progAddr),
         .prog_data (progData)
      );
   end

   // Free-running clock, 10 time units per period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Model state: a pending fetch has a latched PC and edges left until completion
   logic [31:0] modelMem [256];
   bit          pend     [NDUT];
   int          remEdges [NDUT];
   logic [31:0] pcLatch  [NDUT];
   logic [31:0] expInst  [NDUT];
   bit          expReady [NDUT];
   bit          expFault [NDUT];
   bit          expBusy  [NDUT];
   bit          modelLive = 0;

   // A fetch completes by reading the model memory (before this edge's write lands)
   task automatic modelComplete(input int k);
      bit bad;
      bad = (pcLatch[k][1:0] != 2'b00) || (pcLatch[k] >= 32'h400);
      expFault[k] = bad;
      expInst[k]  = bad ? 32'h0 : modelMem[pcLatch[k][9:2]];
      pend[k]     = 0;
   endtask

   // Advance the model on every rising edge using the inputs driven before it
   always @(posedge clock) begin
      for (int k = 0; k < NDUT; k++) begin
         if (reset) begin
            pend[k]     = 0;
            expReady[k] = 0;
            expFault[k] = 0;
            expInst[k]  = 32'h0;
            expBusy[k]  = 0;
         end else begin
            bit wasPend;
            bit rdy;
            wasPend = pend[k];
            rdy     = 0;
            if (pend[k]) begin
               remEdges[k]--;
               if (remEdges[k] == 0) begin
                  modelComplete(k);
                  rdy = 1;
               end
            end
            if (!wasPend && req) begin
               pend[k]     = 1;
               remEdges[k] = WAITS[k];
               pcLatch[k]  = pcIn;
               if (remEdges[k] == 0) begin
                  modelComplete(k);
                  rdy = 1;
               end
            end
            expReady[k] = rdy;
            expBusy[k]  = pend[k] || rdy;
         end
      end
      if (progWe && !reset) modelMem[progAddr] = progData;
      if (reset) modelLive = 1;
   end

   // Compare every DUT against the model on each falling edge once reset has been seen
   always @(negedge clock) begin
      if (modelLive) begin
         for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (readyV[k] !== expReady[k] || busyV[k] !== expBusy[k] ||
                faultV[k] !== expFault[k] || instV[k] !== expInst[k]) begin
               errors++;
               $display("[TB] FAIL model dut%0d t=%0t actual rdy=%b busy=%b flt=%b inst=%h expected rdy=%b busy=%b flt=%b inst=%h",
                        k, $time, readyV[k], busyV[k], faultV[k], instV[k],
                        expReady[k], expBusy[k], expFault[k], expInst[k]);
            end
         end
      end
   end

   // Drive one cycle of inputs, then wait for the next falling edge
   task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic we,
                                input logic [7:0] addr, input logic [31:0] data);
      req      = r;
      pcIn     = pc;
      progWe   = we;
      progAddr = addr;
      progData = data;
      @(negedge clock);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 8'h0, 32'h0);
   endtask

   // Literal comparison against a hand-computed value
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   logic [31:0] prog [8];
   logic [31:0] t2Exp [3];
   int          pulses;
   logic [31:0] pulseInst;

   // Directed sequence
   initial begin
      prog  = '{32'h20080003, 32'h20090004, 32'h01285020, 32'h8D280004,
                32'h01094027, 32'h0149582A, 32'h012A602A, 32'h08000002};
      t2Exp = '{32'h20080003, 32'h20090004, 32'h01285020};
      reset = 1'b1;
      req = 1'b0; pcIn = '0; progWe = 1'b0; progAddr = '0; progData = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      checkOutput("reset ready", 32'(readyV[W0]), 32'd0);
      checkOutput("reset busy",  32'(busyV[W0]),  32'd0);
      checkOutput("reset fault", 32'(faultV[W0]), 32'd0);
      checkOutput("reset inst",  instV[W0],       32'h0);

      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 8'(i), prog[i]);
      idleCycles(1);

      // Zero-wait fetch of the last preloaded word
      applyStimulus(1'b1, 32'h1C, 1'b0, 8'h0, 32'h0);
      checkOutput("t1 ready", 32'(readyV[W0]), 32'd1);
      checkOutput("t1 inst",  instV[W0],       32'h08000002);
      checkOutput("t1 fault", 32'(faultV[W0]), 32'd0);
      idleCycles(8);

      // Three-wait-state back-to-back fetches with req held high
      for (int j = 0; j < 3; j++) begin
         for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b1, 32'(4 * j), 1'b0, 8'h0, 32'h0);
            checkOutput($sformatf("t2 busy j%0d c%0d", j, c), 32'(busyV[W3]), 32'd1);
            checkOutput($sformatf("t2 ready j%0d c%0d", j, c), 32'(readyV[W3]), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) checkOutput($sformatf("t2 inst j%0d", j), instV[W3], t2Exp[j]);
         end
      end
      idleCycles(8);

      // Misaligned, out-of-range, then a good fetch that clears fault
      applyStimulus(1'b1, 32'h6, 1'b0, 8'h0, 32'h0);
      checkOutput("t3 misaligned fault", 32'(faultV[W0]), 32'd1);
      checkOutput("t3 misaligned inst",  instV[W0],       32'h0);
      applyStimulus(1'b1, 32'h400, 1'b0, 8'h0, 32'h0);
      checkOutput("t3 range fault", 32'(faultV[W0]), 32'd1);
      checkOutput("t3 range inst",  instV[W0],       32'h0);
      applyStimulus(1'b1, 32'h8, 1'b0, 8'h0, 32'h0);
      checkOutput("t3 good fault", 32'(faultV[W0]), 32'd0);
      checkOutput("t3 good inst",  instV[W0],       32'h01285020);
      idleCycles(8);

      // Write word 3 on the same edge its fetch reads it
      applyStimulus(1'b1, 32'hC, 1'b1, 8'd3, 32'hDEADBEEF);
      checkOutput("t4 old data", instV[W0], 32'h8D280004);
      idleCycles(1);
      applyStimulus(1'b1, 32'hC, 1'b0, 8'h0, 32'h0);
      checkOutput("t4 new data", instV[W0], 32'hDEADBEEF);
      idleCycles(8);

      // Reset in the middle of a five-wait-state fetch
      applyStimulus(1'b1, 32'h4, 1'b0, 8'h0, 32'h0);
      idleCycles(1);
      reset = 1'b1;
      idleCycles(1);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idleCycles(1);
         checkOutput($sformatf("t5 no ready %0d", i), 32'(readyV[W5]), 32'd0);
      end
      checkOutput("t5 busy", 32'(busyV[W5]), 32'd0);
      checkOutput("t5 inst", instV[W5],      32'h0);
      applyStimulus(1'b1, 32'h4, 1'b0, 8'h0, 32'h0);
      idleCycles(5);
      checkOutput("t5 refetch ready", 32'(readyV[W5]), 32'd1);
      checkOutput("t5 refetch inst",  instV[W5],       32'h20090004);
      idleCycles(8);

      // pc_in and req wiggle during WAIT; the latched PC wins, one pulse only
      pulses    = 0;
      pulseInst = 32'h0;
      for (int s = 0; s < 10; s++) begin
         case (s)
            0:       applyStimulus(1'b1, 32'h8,  1'b0, 8'h0, 32'h0);
            1:       applyStimulus(1'b0, 32'h1C, 1'b0, 8'h0, 32'h0);
            2:       applyStimulus(1'b1, 32'h10, 1'b0, 8'h0, 32'h0);
            3:       applyStimulus(1'b1, 32'h14, 1'b0, 8'h0, 32'h0);
            default: applyStimulus(1'b0, 32'h1C, 1'b0, 8'h0, 32'h0);
         endcase
         if (readyV[W3] === 1'b1) begin
            pulses++;
            pulseInst = instV[W3];
         end
      end
      checkOutput("t6 pulses", 32'(pulses), 32'd1);
      checkOutput("t6 inst",   pulseInst,   32'h01285020);

      idleCycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
